// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the iterative AES-128 encryption core.
package aes_pkg;

    localparam int unsigned BLK_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned NROUNDS = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_fsm_e;

    // Round constants, indexed by round number; unused slots are zero
    localparam logic [0:15][BYTE_W-1:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Forward S-box, entry 0 is the leftmost byte
    localparam logic [0:255][BYTE_W-1:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by x in GF(2^8) modulo 0x11b
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box applied to each byte of a word
    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Row r rotates left by r columns; byte s[r][c] sits at index 4c+r from the MSB
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Column-wise multiply by {02,03,01,01} circulant
    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0]  o;
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_c
);

    // Table lookup
    assign out_c = SBOX[in_byte];

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.
// Optional feature macro: AES_BUSY_OUT_EN adds the registered busy output.
module aes_cipher
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [BLK_W-1:0]  key,
    input  logic [BLK_W-1:0]  text_in,
    output logic              done,
`ifdef AES_BUSY_OUT_EN
    output logic              busy,
`endif
    output logic [BLK_W-1:0]  text_out
);

    aes_fsm_e           fsm_q, fsm_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   rk_q, rk_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               done_q, done_d;
    logic [BLK_W-1:0]   text_out_q, text_out_d;

    logic [BLK_W-1:0]   sub_bytes;
    logic [BLK_W-1:0]   shifted;
    logic [BLK_W-1:0]   mixed;
    logic [WORD_W-1:0]  rot_w3;
    logic [WORD_W-1:0]  sub_w3;
    logic [WORD_W-1:0]  key_t;
    logic [BLK_W-1:0]   rk_next;

    // Data path SubBytes, one S-box per state byte
    for (genvar i = 0; i < 16; i++) begin : g_data_sbox
        aes_sbox u_sbox (
            .in_byte (blk_q[127-8*i -: 8]),
            .out_c   (sub_bytes[127-8*i -: 8])
        );
    end

    assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

    // Key schedule SubWord on the rotated last word
    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (
            .in_byte (rot_w3[31-8*j -: 8]),
            .out_c   (sub_w3[31-8*j -: 8])
        );
    end

    // Round transforms and next round key
    always_comb begin
        shifted = shift_rows(sub_bytes);
        mixed   = mix_columns(shifted);
        key_t   = sub_w3 ^ {RCON[round_q], 24'h0};
        rk_next[127:96] = rk_q[127:96] ^ key_t;
        rk_next[95:64]  = rk_q[95:64]  ^ rk_next[127:96];
        rk_next[63:32]  = rk_q[63:32]  ^ rk_next[95:64];
        rk_next[31:0]   = rk_q[31:0]   ^ rk_next[63:32];
    end

    // Next-state: round sequencing, final round capture, load/restart
    always_comb begin
        fsm_d      = fsm_q;
        blk_d      = blk_q;
        rk_d       = rk_q;
        round_d    = round_q;
        done_d     = 1'b0;
        text_out_d = text_out_q;

        if (fsm_q == ST_RUN) begin
            if (round_q == ROUND_W'(NROUNDS)) begin
                text_out_d = shifted ^ rk_next;
                done_d     = 1'b1;
                fsm_d      = ST_IDLE;
                round_d    = '0;
            end else begin
                blk_d   = mixed ^ rk_next;
                rk_d    = rk_next;
                round_d = round_q + ROUND_W'(1);
            end
        end

        // A load overrides any round in flight but leaves a completing block's done intact
        if (ld) begin
            blk_d   = text_in ^ key;
            rk_d    = key;
            round_d = ROUND_W'(1);
            fsm_d   = ST_RUN;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            blk_q      <= '0;
            rk_q       <= '0;
            round_q    <= '0;
            done_q     <= 1'b0;
            text_out_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            blk_q      <= blk_d;
            rk_q       <= rk_d;
            round_q    <= round_d;
            done_q     <= done_d;
            text_out_q <= text_out_d;
        end
    end

    assign done     = done_q;
    assign text_out = text_out_q;

`ifdef AES_BUSY_OUT_EN
    // Busy mirrors the run state register
    assign busy = (fsm_q == ST_RUN);
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher using FIPS-197 vectors.
module tb_aes_cipher;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct packed {
        logic [127:0] ct;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic         done;
    logic [127:0] text_out;
`ifdef AES_BUSY_OUT_EN
    logic         busy;
`endif

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [31:0]  cyc      = '0;
    exp_t         sb_q[$];

    aes_cipher dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .done     (done),
`ifdef AES_BUSY_OUT_EN
        .busy     (busy),
`endif
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one load; flush drops any block that this load aborts
    task automatic start(input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] ct, input bit flush);
        exp_t e;
        @(negedge clk);
        key     = k;
        text_in = p;
        ld      = 1'b1;
        if (flush) sb_q.delete();
        e.ct  = ct;
        e.cyc = cyc + 32'd11;
        sb_q.push_back(e);
        @(negedge clk);
        ld      = 1'b0;
        key     = $urandom();
        text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Wait, bounded, for all expected completions
    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val(tag, 128'(sb_q.size()), 128'd0);
    endtask

    // Completion monitor: every done must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 128'd1, 128'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("text_out", text_out, e.ct);
                check_val("done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        repeat (3) @(negedge clk);
        check_val("reset_done", 128'(done), 128'd0);
        check_val("reset_text_out", text_out, 128'd0);
`ifdef AES_BUSY_OUT_EN
        check_val("reset_busy", 128'(busy), 128'd0);
`endif
        rst = 1'b0;

        // FIPS-197 App. B, C.1 and all-zero vectors
        start(KEY_B, PT_B, CT_B, 1'b0);
`ifdef AES_BUSY_OUT_EN
        check_val("busy_running", 128'(busy), 128'd1);
`endif
        drain("drain_app_b");
        start(KEY_C, PT_C, CT_C, 1'b0);
        drain("drain_c1");
        start('0, '0, CT_Z, 1'b0);
        drain("drain_zero");

        // Restart mid-operation: only the second block completes
        start(KEY_B, PT_B, CT_B, 1'b0);
        repeat (2) @(negedge clk);
        start(KEY_C, PT_C, CT_C, 1'b1);
        drain("drain_restart");

        // Back-to-back: second load on the completion edge of the first
        start(KEY_C, PT_C, CT_C, 1'b0);
        repeat (8) @(negedge clk);
        start('0, '0, CT_Z, 1'b0);
        drain("drain_back_to_back");

        // Reset mid-operation: no done, text_out cleared
        start(KEY_B, PT_B, CT_B, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_val("reset_abort_text_out", text_out, 128'd0);
        check_val("reset_abort_done", 128'(done), 128'd0);

        // Fresh run after reset
        start(KEY_B, PT_B, CT_B, 1'b0);
        drain("drain_after_reset");

        // Hold: outputs stable while idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("hold_text_out", text_out, CT_B);
            check_val("hold_done", 128'(done), 128'd0);
`ifdef AES_BUSY_OUT_EN
            check_val("hold_busy", 128'(busy), 128'd0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_cipher.md
# aes_cipher

Iterative AES-128 encryption core with one round per clock and on-the-fly key expansion. It accepts a 128-bit key and plaintext block on a load strobe. It returns the ciphertext with a one-cycle done pulse. It sits behind the bus/register front end, which drives key and text_in and samples text_out on done.

## Interface
- No parameters.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ld  in  1  start strobe; key and text_in are sampled on the rising edge where ld=1.
- key  in  128  cipher key; bit 127 is the first byte of FIPS-197 order.
- text_in  in  128  plaintext block; bit 127 is the first byte of FIPS-197 order.
- done  out  1  registered one-cycle completion pulse.
- text_out  out  128  registered ciphertext; held until the next completion.
- busy  out  1  present only with AES_BUSY_OUT_EN.

## Operation
- State, column and byte ordering follow FIPS-197:
  - State byte s[r][c] = bits 127-8*(4c+r) downto 120-8*(4c+r).
  - Word w0 = bits 127:96.
- Load (edge with ld=1, rst=0):
  - state <= text_in ^ key.
  - roundkey <= key.
  - round counter <= 1.
  - Core becomes active.
- Active, round r=1..9, one per edge:
  - roundkey' = KeyExpand(roundkey, Rcon[r]).
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ roundkey'.
  - roundkey <= roundkey'.
  - r increments.
- Round 10, final:
  - state = ShiftRows(SubBytes(state)) ^ KeyExpand(roundkey, Rcon[10]), with no MixColumns.
  - This result is written to text_out.
  - done <= 1.
  - Core goes idle.
- KeyExpand(k, rc): t = SubWord(RotWord(k.w3)) ^ {rc,24'h0}.
  - w0' = w0 ^ t.
  - w1' = w1 ^ w0'.
  - w2' = w2 ^ w1'.
  - w3' = w3 ^ w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses GF(2^8) with polynomial 0x11b. xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- ld while active aborts the current operation and restarts with the newly sampled key and text_in. No done is produced for the aborted block.
- ld on the same edge as done output asserting: done still pulses for the finished block, and the new operation starts.
- Idle: text_out holds its last value; done = 0.
- rst: done=0, text_out=0, counter=0, core idle. Reset mid-operation aborts with no done. rst has priority over ld.

## Timing
- ld sampled at edge E0. Rounds 1-9 occur at E1-E9. Round 10 and the text_out/done update occur at E10.
- done is high for exactly the cycle after E10, giving a latency of 10 clocks.
- text_out is valid from E10 until the next completion.
- Back-to-back throughput is one block per 10 clocks; ld may be asserted on E10 itself.
- Key and text_in need to be stable only at the sampling edge.

## Configuration
- AES_BUSY_OUT_EN defined:
  - Adds output busy.
  - busy is registered and is 1 from the edge after ld is sampled through the cycle before done.
  - busy is 0 in reset and when idle.
- Macro undefined: port busy is absent and behaviour is otherwise identical.

## Structure
- Package aes_pkg holds:
  - The Rcon constant array.
  - The 256-entry S-box constant.
  - Functions xtime, sub_word, shift_rows, mix_columns.
- One sub-module, aes_sbox: 8-bit combinational lookup.
  - 16 instances serve the data path.
  - 4 instances serve key expansion.
- The top holds the state, roundkey, counter and output registers.

## Test plan
- FIPS-197 App. B vector:
  - key 2b7e151628aed2a6abf7158809cf4f3c, text_in 3243f6a8885a308d313198a2e0370734, ld for 1 cycle.
  - Required: text_out 3925841d02dc09fbdc118597196a0b32 with done high exactly 10 clocks after the ld edge, and for one cycle only.
- FIPS-197 C.1 vector:
  - key 000102030405060708090a0b0c0d0e0f, text_in 00112233445566778899aabbccddeeff.
  - Required: text_out 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and text_in -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Restart and back-to-back:
  - Start the App. B vector, then re-assert ld with the C.1 vector at cycle 4. Required: only one done, 10 clocks after the second ld, carrying 69c4…c55a.
  - Start the C.1 vector, then assert ld with the zero vector on the completion edge. Required: two done pulses 10 clocks apart, with the correct outputs.
- Reset:
  - Assert rst at cycle 5 of an operation. Required: done never asserts and text_out = 0.
  - After rst releases, a fresh App. B run passes.
- Hold: after done, leave ld low for 20 cycles. Required: text_out is unchanged, done = 0, and busy = 0 if enabled.
